// File: rtl/time_counter_gen_if.sv
// Bundle of control, load and display signals for time_counter_gen.
// master drives controls and load values; slave is the counter itself.
interface time_counter_gen_if;
    logic       tick;
    logic       hold;
    logic       mode_12h;
    logic       load_new_c;
    logic [3:0] new_current_time_ms_hr;
    logic [3:0] new_current_time_ls_hr;
    logic [3:0] new_current_time_ms_min;
    logic [3:0] new_current_time_ls_min;
    logic [3:0] current_time_ms_hr;
    logic [3:0] current_time_ls_hr;
    logic [3:0] current_time_ms_min;
    logic [3:0] current_time_ls_min;
    logic       pm;
    logic       day_rollover;
    logic       load_err;

    modport master (
        output tick, hold, mode_12h, load_new_c,
        output new_current_time_ms_hr, new_current_time_ls_hr,
        output new_current_time_ms_min, new_current_time_ls_min,
        input  current_time_ms_hr, current_time_ls_hr,
        input  current_time_ms_min, current_time_ls_min,
        input  pm, day_rollover, load_err
    );

    modport slave (
        input  tick, hold, mode_12h, load_new_c,
        input  new_current_time_ms_hr, new_current_time_ls_hr,
        input  new_current_time_ms_min, new_current_time_ls_min,
        output current_time_ms_hr, current_time_ls_hr,
        output current_time_ms_min, current_time_ls_min,
        output pm, day_rollover, load_err
    );
endinterface

// File: rtl/time_counter_gen.sv
// BCD time-of-day counter with tick prescaler, hold and 12h/24h display.
// Optional load range check with load_err pulse: TIME_COUNTER_LOAD_CHECK_EN.
module time_counter_gen #(
    parameter int TICKS_PER_MIN = 60,
    parameter int PRE_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    time_counter_gen_if.slave  bus
);

    logic [3:0]       hr_t, hr_u, mn_t, mn_u;
    logic [3:0]       n_hr_t, n_hr_u, n_mn_t, n_mn_u;
    logic [PRE_W-1:0] pre;
    logic             last_tick;
    logic             wrap;
    logic             load_ok;
    logic             do_load;
    logic             accept;
    logic             roll;

`ifdef TIME_COUNTER_LOAD_CHECK_EN
    logic             lerr;

    assign load_ok = (bus.new_current_time_ms_hr <= 4'd2)
                  && (bus.new_current_time_ls_hr <= 4'd9)
                  && !(bus.new_current_time_ms_hr == 4'd2
                       && bus.new_current_time_ls_hr > 4'd3)
                  && (bus.new_current_time_ms_min <= 4'd5)
                  && (bus.new_current_time_ls_min <= 4'd9);
`else
    assign load_ok = 1'b1;
`endif

    assign do_load   = bus.load_new_c && load_ok;
    assign accept    = bus.tick && !bus.hold && !do_load;
    assign last_tick = (pre == PRE_W'(TICKS_PER_MIN - 1));

    // Next minute value, digit-equality rules checked in priority order
    always_comb begin
        n_hr_t = hr_t;
        n_hr_u = hr_u;
        n_mn_t = mn_t;
        n_mn_u = mn_u;
        wrap   = 1'b0;
        if (hr_t == 4'd2 && hr_u == 4'd3 && mn_t == 4'd5 && mn_u == 4'd9) begin
            n_hr_t = 4'd0;
            n_hr_u = 4'd0;
            n_mn_t = 4'd0;
            n_mn_u = 4'd0;
            wrap   = 1'b1;
        end else if (hr_u == 4'd9 && mn_t == 4'd5 && mn_u == 4'd9) begin
            n_hr_t = hr_t + 4'd1;
            n_hr_u = 4'd0;
            n_mn_t = 4'd0;
            n_mn_u = 4'd0;
        end else if (mn_t == 4'd5 && mn_u == 4'd9) begin
            n_hr_u = hr_u + 4'd1;
            n_mn_t = 4'd0;
            n_mn_u = 4'd0;
        end else if (mn_u == 4'd9) begin
            n_mn_t = mn_t + 4'd1;
            n_mn_u = 4'd0;
        end else begin
            n_mn_u = mn_u + 4'd1;
        end
    end

    // Time and prescaler: load beats an accepted tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hr_t <= 4'd0;
            hr_u <= 4'd0;
            mn_t <= 4'd0;
            mn_u <= 4'd0;
            pre  <= '0;
        end else if (do_load) begin
            hr_t <= bus.new_current_time_ms_hr;
            hr_u <= bus.new_current_time_ls_hr;
            mn_t <= bus.new_current_time_ms_min;
            mn_u <= bus.new_current_time_ls_min;
            pre  <= '0;
        end else if (accept) begin
            if (last_tick) begin
                pre  <= '0;
                hr_t <= n_hr_t;
                hr_u <= n_hr_u;
                mn_t <= n_mn_t;
                mn_u <= n_mn_u;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    // One-cycle pulse after the 23:59 -> 00:00 advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) roll <= 1'b0;
        else        roll <= accept && last_tick && wrap;
    end

`ifdef TIME_COUNTER_LOAD_CHECK_EN
    // One-cycle pulse after a rejected load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lerr <= 1'b0;
        else        lerr <= bus.load_new_c && !load_ok;
    end
    assign bus.load_err = lerr;
`else
    assign bus.load_err = 1'b0;
`endif

    assign bus.day_rollover = roll;

    // 12h display mapping; internal time stays 24h
    always_comb begin
        bus.current_time_ms_hr = hr_t;
        bus.current_time_ls_hr = hr_u;
        bus.pm                 = 1'b0;
        if (bus.mode_12h) begin
            bus.pm = (hr_t == 4'd2) || (hr_t == 4'd1 && hr_u >= 4'd2);
            if (hr_t == 4'd0 && hr_u == 4'd0) begin
                bus.current_time_ms_hr = 4'd1;
                bus.current_time_ls_hr = 4'd2;
            end else if (hr_t == 4'd1 && hr_u >= 4'd3) begin
                bus.current_time_ms_hr = 4'd0;
                bus.current_time_ls_hr = hr_u - 4'd2;
            end else if (hr_t == 4'd2 && hr_u <= 4'd1) begin
                bus.current_time_ms_hr = 4'd0;
                bus.current_time_ls_hr = hr_u + 4'd8;
            end else if (hr_t == 4'd2) begin
                bus.current_time_ms_hr = 4'd1;
                bus.current_time_ls_hr = hr_u - 4'd2;
            end
        end
    end

    assign bus.current_time_ms_min = mn_t;
    assign bus.current_time_ls_min = mn_u;

endmodule

// File: tb/tb_time_counter_gen.sv
// Self-checking bench for time_counter_gen against a minutes-of-day model.
// Covers prescaler, rollovers, hold, 12h mapping, async reset, load check.
module tb_time_counter_gen;

    localparam int TPM = 60;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    int   m_mins;
    int   m_pre;
    bit   m_roll;
    bit   m_lerr;

    time_counter_gen_if bus ();

    time_counter_gen #(.TICKS_PER_MIN(TPM), .PRE_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag);
        int h;
        int hd;
        bit pe;
        logic [18:0] obs;
        logic [18:0] exp;
        h  = m_mins / 60;
        hd = h;
        pe = 1'b0;
        if (bus.mode_12h) begin
            pe = (h >= 12);
            hd = h % 12;
            if (hd == 0) hd = 12;
        end
        exp = {4'(hd / 10), 4'(hd % 10), 4'((m_mins % 60) / 10),
               4'(m_mins % 10), pe, m_roll, m_lerr};
        obs = {bus.current_time_ms_hr, bus.current_time_ls_hr,
               bus.current_time_ms_min, bus.current_time_ls_min,
               bus.pm, bus.day_rollover, bus.load_err};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got hhmm/pm/roll/err=%h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_const(string tag, logic [3:0] a, logic [3:0] b,
                               logic [3:0] c, logic [3:0] d, logic p);
        logic [16:0] obs;
        logic [16:0] exp;
        exp = {a, b, c, d, p};
        obs = {bus.current_time_ms_hr, bus.current_time_ls_hr,
               bus.current_time_ms_min, bus.current_time_ls_min, bus.pm};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got hhmm/pm=%h want %h", tag, obs, exp);
        end
    endtask

    task automatic check_roll(string tag, logic r);
        n_tests++;
        assert (bus.day_rollover === r) else begin
            n_fail++;
            $error("FAIL %s: got roll=%b want %b", tag, bus.day_rollover, r);
        end
    endtask

    function automatic bit legal(int a, int b, int c, int d);
        return ((a * 10 + b) < 24) && (b <= 9) && (c <= 5) && (d <= 9);
    endfunction

    task automatic cyc(bit t, bit h, bit ld, int a, int b, int c, int d,
                       string tag);
        bit ok;
        bus.tick                    = t;
        bus.hold                    = h;
        bus.load_new_c              = ld;
        bus.new_current_time_ms_hr  = 4'(a);
        bus.new_current_time_ls_hr  = 4'(b);
        bus.new_current_time_ms_min = 4'(c);
        bus.new_current_time_ls_min = 4'(d);
        @(posedge clk);
`ifdef TIME_COUNTER_LOAD_CHECK_EN
        ok = legal(a, b, c, d);
`else
        ok = 1'b1;
`endif
        m_roll = 1'b0;
        m_lerr = 1'b0;
        if (ld && ok) begin
            m_mins = (a * 10 + b) * 60 + c * 10 + d;
            m_pre  = 0;
        end else begin
            if (ld) m_lerr = 1'b1;
            if (t && !h) begin
                m_pre++;
                if (m_pre == TPM) begin
                    m_pre = 0;
                    if (m_mins == 1439) m_roll = 1'b1;
                    m_mins = (m_mins + 1) % 1440;
                end
            end
        end
        #1;
        check(tag);
    endtask

    task automatic ticks(int n, bit h, string tag);
        for (int i = 0; i < n; i++) cyc(1'b1, h, 1'b0, 0, 0, 0, 0, tag);
    endtask

    task automatic load(int a, int b, int c, int d, bit t, string tag);
        cyc(t, 1'b0, 1'b1, a, b, c, d, tag);
    endtask

    initial begin
        int a, b, c, d, hh, mm;
        n_tests = 0;
        n_fail  = 0;
        m_mins  = 0;
        m_pre   = 0;
        m_roll  = 0;
        m_lerr  = 0;
        reset   = 1'b0;
        bus.tick = 1'b0;
        bus.hold = 1'b0;
        bus.mode_12h = 1'b0;
        bus.load_new_c = 1'b0;
        bus.new_current_time_ms_hr  = 4'd0;
        bus.new_current_time_ls_hr  = 4'd0;
        bus.new_current_time_ms_min = 4'd0;
        bus.new_current_time_ls_min = 4'd0;

        repeat (2) @(posedge clk);
        #1;
        check_const("reset_24h", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        check("reset_24h_all");
        bus.mode_12h = 1'b1;
        #1;
        check_const("reset_12h", 4'd1, 4'd2, 4'd0, 4'd0, 1'b0);
        bus.mode_12h = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        load(1, 2, 3, 4, 1'b0, "load_1234");
        ticks(TPM - 1, 1'b0, "pre_1234");
        check_const("hold_1234", 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        ticks(1, 1'b0, "adv_1235");
        check_const("adv_1235c", 4'd1, 4'd2, 4'd3, 4'd5, 1'b0);

        load(2, 3, 5, 9, 1'b0, "load_2359");
        ticks(TPM, 1'b0, "wrap");
        check_const("wrap_0000", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        check_roll("roll_hi", 1'b1);
        ticks(1, 1'b0, "post_wrap");
        check_roll("roll_lo", 1'b0);

        load(0, 9, 5, 9, 1'b0, "load_0959");
        ticks(TPM, 1'b0, "to_1000");
        check_const("c_1000", 4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
        load(1, 9, 5, 9, 1'b0, "load_1959");
        ticks(TPM, 1'b0, "to_2000");
        check_const("c_2000", 4'd2, 4'd0, 4'd0, 4'd0, 1'b0);

        bus.mode_12h = 1'b1;
        load(1, 3, 0, 5, 1'b0, "load_1305_12h");
        check_const("c_0105pm", 4'd0, 4'd1, 4'd0, 4'd5, 1'b1);
        bus.mode_12h = 1'b0;
        #1;
        check_const("c_1305_24h", 4'd1, 4'd3, 4'd0, 4'd5, 1'b0);
        bus.mode_12h = 1'b1;
        load(0, 0, 0, 7, 1'b0, "load_0007_12h");
        check_const("c_1207am", 4'd1, 4'd2, 4'd0, 4'd7, 1'b0);
        bus.mode_12h = 1'b0;
        #1;
        check_const("c_0007_24h", 4'd0, 4'd0, 4'd0, 4'd7, 1'b0);
        for (int hr = 0; hr < 24; hr++) begin
            bus.mode_12h = 1'b1;
            load(hr / 10, hr % 10, 3, 0, 1'b0, "map12");
        end
        bus.mode_12h = 1'b0;

        load(0, 4, 1, 0, 1'b0, "load_0410");
        ticks(20, 1'b0, "pre20");
        ticks(100, 1'b1, "held");
        ticks(TPM - 21, 1'b0, "resume");
        check_const("c_0410", 4'd0, 4'd4, 4'd1, 4'd0, 1'b0);
        ticks(1, 1'b0, "resume_adv");
        check_const("c_0411", 4'd0, 4'd4, 4'd1, 4'd1, 1'b0);

        ticks(10, 1'b0, "pre_ld");
        load(0, 8, 0, 0, 1'b1, "load_tick_0800");
        ticks(TPM - 1, 1'b0, "pre_0800");
        check_const("c_0800", 4'd0, 4'd8, 4'd0, 4'd0, 1'b0);
        ticks(1, 1'b0, "adv_0801");
        check_const("c_0801", 4'd0, 4'd8, 4'd0, 4'd1, 1'b0);

`ifdef TIME_COUNTER_LOAD_CHECK_EN
        load(2, 4, 0, 0, 1'b0, "bad_2400");
        check_const("c_bad_2400", 4'd0, 4'd8, 4'd0, 4'd1, 1'b0);
        ticks(1, 1'b0, "err_clear");
        load(0, 7, 6, 0, 1'b1, "bad_0760_tick");
        load(2, 3, 5, 9, 1'b0, "good_2359");
        check_const("c_good_2359", 4'd2, 4'd3, 4'd5, 4'd9, 1'b0);
`endif

        load(1, 5, 4, 2, 1'b0, "load_1542");
        ticks(30, 1'b0, "mid_min");
        #2;
        reset  = 1'b0;
        m_mins = 0;
        m_pre  = 0;
        m_roll = 1'b0;
        m_lerr = 1'b0;
        #1;
        check_const("async_rst", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        check("async_rst_all");
        @(posedge clk);
        #1;
        check("rst_held");
        @(negedge clk);
        reset = 1'b1;
        ticks(TPM - 1, 1'b0, "post_rst");
        check_const("c_post_rst", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        ticks(1, 1'b0, "post_rst_adv");
        check_const("c_0001", 4'd0, 4'd0, 4'd0, 4'd1, 1'b0);

        for (int i = 0; i < 4000; i++) begin
            bus.mode_12h = ($urandom_range(0, 7) == 0) ? ~bus.mode_12h
                                                       : bus.mode_12h;
            if ($urandom_range(0, 99) < 2) begin
                hh = $urandom_range(0, 23);
                mm = ($urandom_range(0, 1) == 0) ? 59 : $urandom_range(0, 59);
                a = hh / 10;
                b = hh % 10;
                c = mm / 10;
                d = mm % 10;
`ifdef TIME_COUNTER_LOAD_CHECK_EN
                if ($urandom_range(0, 3) == 0) begin
                    a = $urandom_range(0, 15);
                    b = $urandom_range(0, 15);
                    c = $urandom_range(0, 15);
                    d = $urandom_range(0, 15);
                end
`endif
                cyc($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                    1'b1, a, b, c, d, "rand_load");
            end else begin
                cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                    1'b0, 0, 0, 0, 0, "rand_run");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
